subtractor_rr_sequencer: RTL and testbench

Sequencer and arbiter that shares one 4-bit ripple-borrow subtractor slice between two requesters. It computes a wide unsigned difference A − B − Bin one nibble per cycle, least significant nibble first, and chains the borrow through a register. It sits between two client datapaths and a single result consumer. It replaces per-client wide subtractors where area matters more than latency.

---
 rtl/subtractor_rr_sequencer.sv | 146 ++++++++++++++
 tb/tb_subtractor_rr_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_rr_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : subtractor_rr_sequencer
//  Purpose  : Shares one 4-bit ripple-borrow subtract slice between two
//             requesters. Computes A - B - Bin one nibble per cycle, LSN
//             first, with the borrow chained through a register. Ties are
//             resolved round-robin against the last-granted requester.
//  Revision : 1.0 - initial release
// ============================================================================
module subtractor_rr_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [4*NIBBLES-1:0]   req0_A,
  input  logic [4*NIBBLES-1:0]   req0_B,
  input  logic                   req0_Bin,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [4*NIBBLES-1:0]   req1_A,
  input  logic [4*NIBBLES-1:0]   req1_B,
  input  logic                   req1_Bin,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   res_D,
  output logic                   res_Bout,
  output logic                   res_id,
  output logic                   busy
);

  localparam int c_w  = 4 * NIBBLES;
  localparam int c_kw = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_kw-1:0] c_last_k = c_kw'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_kw-1:0]   r_k;
  logic              r_borrow;
  logic              r_last;
  logic [c_w-1:0]    r_a;
  logic [c_w-1:0]    r_b;
  logic [c_w-1:0]    r_res_d;
  logic              r_res_bout;
  logic              r_res_id;
  logic              r_res_valid;
  logic              r_busy;

  logic              w_idle;
  logic              w_gid;
  logic              w_accept;
  logic [c_w-1:0]    w_sel_a;
  logic [c_w-1:0]    w_sel_b;
  logic              w_sel_bin;
  logic [3:0]        w_a_nib;
  logic [3:0]        w_b_nib;
  logic [4:0]        w_diff;
  logic [c_kw+1:0]   w_bit_idx;

  // Grant selection: a lone valid wins; on a tie the requester that was not
  // granted last time wins. Ready is gated by reset so it reads 0 in reset.
  assign w_idle     = (r_state == S_IDLE);
  assign w_gid      = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign req0_ready = ~rst & w_idle & req0_valid & ~w_gid;
  assign req1_ready = ~rst & w_idle & req1_valid &  w_gid;
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_a    = w_gid ? req1_A   : req0_A;
  assign w_sel_b    = w_gid ? req1_B   : req0_B;
  assign w_sel_bin  = w_gid ? req1_Bin : req0_Bin;

  // The shared 4-bit slice; bit 4 of the 5-bit difference is the borrow-out.
  assign w_bit_idx  = {r_k, 2'b00};
  assign w_a_nib    = r_a[w_bit_idx +: 4];
  assign w_b_nib    = r_b[w_bit_idx +: 4];
  assign w_diff     = {1'b0, w_a_nib} - {1'b0, w_b_nib} - {4'b0000, r_borrow};

  assign res_valid  = r_res_valid;
  assign res_D      = r_res_d;
  assign res_Bout   = r_res_bout;
  assign res_id     = r_res_id;
  assign busy       = r_busy;

  // Sequencer FSM: accept in IDLE, one nibble per RUN cycle, hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_borrow    <= 1'b0;
      r_last      <= 1'b1;
      r_a         <= '0;
      r_b         <= '0;
      r_res_d     <= '0;
      r_res_bout  <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_borrow <= w_sel_bin;
            r_res_id <= w_gid;
            r_last   <= w_gid;
            r_k      <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_res_d[w_bit_idx +: 4] <= w_diff[3:0];
          r_borrow                <= w_diff[4];
          if (r_k == c_last_k) begin
            r_res_bout  <= w_diff[4];
            r_res_valid <= 1'b1;
            r_k         <= '0;
            r_state     <= S_DONE;
          end else begin
            r_k <= r_k + c_kw'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_subtractor_rr_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_subtractor_rr_sequencer
//  Purpose  : Scoreboard bench for subtractor_rr_sequencer (NIBBLES=2 and 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_subtractor_rr_sequencer;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req0_Bin;
  logic req1_valid, req1_ready, req1_Bin;
  logic [7:0] req0_A, req0_B, req1_A, req1_B, res_D;
  logic res_valid, res_ready, res_Bout, res_id, busy;

  logic d4_req0_valid, d4_req0_ready, d4_req1_ready, d4_res_valid;
  logic d4_res_ready, d4_res_Bout, d4_res_id, d4_busy;
  logic [15:0] d4_req0_A, d4_req0_B, d4_res_D;

  always #5 clk = ~clk;

  subtractor_rr_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A),
    .req0_B(req0_B), .req0_Bin(req0_Bin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A),
    .req1_B(req1_B), .req1_Bin(req1_Bin),
    .res_valid(res_valid), .res_ready(res_ready), .res_D(res_D),
    .res_Bout(res_Bout), .res_id(res_id), .busy(busy)
  );

  subtractor_rr_sequencer #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(d4_req0_valid), .req0_ready(d4_req0_ready), .req0_A(d4_req0_A),
    .req0_B(d4_req0_B), .req0_Bin(1'b0),
    .req1_valid(1'b0), .req1_ready(d4_req1_ready), .req1_A(16'h0000),
    .req1_B(16'h0000), .req1_Bin(1'b0),
    .res_valid(d4_res_valid), .res_ready(d4_res_ready), .res_D(d4_res_D),
    .res_Bout(d4_res_Bout), .res_id(d4_res_id), .busy(d4_busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       bout;
    logic       id;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = -100;
  int   last_acc = -1;
  bit   spacing_en = 1'b0;
  logic prev_rv = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin);
    logic [8:0] t;
    t = {1'b0, a} - {1'b0, b} - {8'h00, bin};
    model.d    = t[7:0];
    model.bout = t[8];
    model.id   = id;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: accept timing, result latency, scoreboard pop on result handshake
  always @(negedge clk) begin
    exp_t e;
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
      if (spacing_en && last_acc >= 0) check_value("accept_spacing", cyc - last_acc, 4);
      last_acc = cyc;
      acc_cyc  = cyc;
    end
    if (res_valid && !prev_rv) check_value("latency", cyc - acc_cyc, N + 1);
    if (res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check_value("sb_unexpected_result", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_value("res_D", res_D, e.d);
        check_value("res_Bout", res_Bout, e.bout);
        check_value("res_id", res_id, e.id);
      end
    end
    prev_rv = res_valid;
  end

  task automatic send(input logic id, input logic [7:0] a, input logic [7:0] b, input logic bin);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (id) begin
      req1_A = a; req1_B = b; req1_Bin = bin; req1_valid = 1'b1;
    end else begin
      req0_A = a; req0_B = b; req0_Bin = bin; req0_valid = 1'b1;
    end
    sb_q.push_back(model(id, a, b, bin));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((id && req1_ready) || (!id && req0_ready)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_value("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && !res_valid && !req0_valid && !req1_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_value("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_res_valid"}, res_valid, 0);
    check_value({tag, "_res_D"}, res_D, 0);
    check_value({tag, "_res_Bout"}, res_Bout, 0);
    check_value({tag, "_res_id"}, res_id, 0);
    check_value({tag, "_busy"}, busy, 0);
    check_value({tag, "_req0_ready"}, req0_ready, 0);
    check_value({tag, "_req1_ready"}, req1_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_seen;
    int acc4;
    bit got;
    rst = 1'b1;
    req0_valid = 0; req0_A = 0; req0_B = 0; req0_Bin = 0;
    req1_valid = 0; req1_A = 0; req1_B = 0; req1_Bin = 0;
    res_ready = 1'b1;
    d4_req0_valid = 0; d4_req0_A = 0; d4_req0_B = 0; d4_res_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Basic arithmetic, including borrow across nibbles and borrow-in only
    send(1'b0, 8'h35, 8'h12, 1'b0); wait_idle();
    send(1'b1, 8'h10, 8'h01, 1'b0); wait_idle();
    send(1'b1, 8'h00, 8'h00, 1'b1); wait_idle();

    // Round-robin with both requesters valid continuously from reset
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req0_A = 8'h50; req0_B = 8'h20; req0_Bin = 1'b0;
    req1_A = 8'h22; req1_B = 8'h33; req1_Bin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) sb_q.push_back(model(1'b0, 8'h50, 8'h20, 1'b0));
      else            sb_q.push_back(model(1'b1, 8'h22, 8'h33, 1'b0));
    end
    last_acc = -1;
    spacing_en = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    acc_seen = 0;
    for (int i = 0; i < 60 && acc_seen < 4; i++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_seen++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    spacing_en = 1'b0;
    check_value("arb_accept_count", acc_seen, 4);
    wait_idle();

    // Result held while consumer stalls; waiting requester not granted
    res_ready = 1'b0;
    send(1'b0, 8'h80, 8'h7F, 1'b0);
    req1_A = 8'h05; req1_B = 8'h01; req1_Bin = 1'b0; req1_valid = 1'b1;
    sb_q.push_back(model(1'b1, 8'h05, 8'h01, 1'b0));
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) check_value("hold_valid_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      check_value("hold_res_valid", res_valid, 1);
      check_value("hold_res_D", res_D, 8'h01);
      check_value("hold_req1_ready", req1_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_value("hold_next_grant", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_idle();

    // Reset in the second RUN cycle aborts the operation
    @(posedge clk); #1;
    req0_A = 8'h99; req0_B = 8'h11; req0_Bin = 1'b0; req0_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_ready) begin got = 1'b1; break; end
    end
    if (!got) check_value("abort_accept_timeout", 0, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_value("abort_no_result", res_valid, 0);
    end
    send(1'b1, 8'h05, 8'h03, 1'b0); wait_idle();

    // NIBBLES=4 instance: full-width borrow chain
    @(posedge clk); #1;
    d4_req0_A = 16'h0000; d4_req0_B = 16'h0001; d4_req0_valid = 1'b1;
    acc4 = -100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d4_req0_ready) begin acc4 = cyc; break; end
    end
    @(posedge clk); #1 d4_req0_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d4_res_valid) begin got = 1'b1; break; end
    end
    check_value("n4_valid_seen", got, 1);
    check_value("n4_latency", cyc - acc4, 5);
    check_value("n4_res_D", d4_res_D, 16'hFFFF);
    check_value("n4_res_Bout", d4_res_Bout, 1);
    check_value("n4_res_id", d4_res_id, 0);

    repeat (3) @(negedge clk);
    check_value("sb_leftover", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
